// File: rtl/hours_counter_cfg.sv
// BCD hours stage: 24-hour internal count with load, non-carrying adjust and carry to the day
// stage, plus 24h / 12h AM-PM display and active-low gfedcba seven-segment decode.
module hours_counter_cfg #(
  parameter int unsigned RESET_HOUR = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en_in,
  input  logic       mode_12h,
  input  logic       load_en,
  input  logic [3:0] load_ten,
  input  logic [3:0] load_unit,
  input  logic       adj_up,
  input  logic       adj_dn,
  output logic       co,
  output logic       load_err,
  output logic [3:0] hour24_ten,
  output logic [3:0] hour24_unit,
  output logic [3:0] hour_ten,
  output logic [3:0] hour_unit,
  output logic       pm,
  output logic [6:0] seg_ten,
  output logic [6:0] seg_unit
);

  // Out-of-range reset hours fall back to midnight.
  localparam int unsigned RstHour = (RESET_HOUR > 23) ? 0 : RESET_HOUR;
  localparam logic [3:0]  RstTen  = 4'(RstHour / 10);
  localparam logic [3:0]  RstUnit = 4'(RstHour % 10);

  logic [3:0] t_q, t_d;
  logic [3:0] u_q, u_d;
  logic       err_q, err_d;

  logic       is_23;
  logic       is_00;
  logic       load_ok;
  logic       adj_any;
  logic [4:0] hour_bin;
  logic [4:0] hour_pm;

  assign is_23   = (t_q == 4'd2) && (u_q == 4'd3);
  assign is_00   = (t_q == 4'd0) && (u_q == 4'd0);
  assign adj_any = adj_up | adj_dn;
  assign load_ok = (load_ten <= 4'd2) && (load_unit <= 4'd9) &&
                   !((load_ten == 4'd2) && (load_unit > 4'd3));

  always_comb begin
    t_d   = t_q;
    u_d   = u_q;
    err_d = 1'b0;
    if (load_en) begin
      if (load_ok) begin
        t_d = load_ten;
        u_d = load_unit;
      end else begin
        err_d = 1'b1;
      end
    end else if (adj_up && !adj_dn) begin
      if (is_23) begin
        t_d = 4'd0;
        u_d = 4'd0;
      end else if (u_q == 4'd9) begin
        t_d = t_q + 4'd1;
        u_d = 4'd0;
      end else begin
        u_d = u_q + 4'd1;
      end
    end else if (adj_dn && !adj_up) begin
      if (is_00) begin
        t_d = 4'd2;
        u_d = 4'd3;
      end else if (u_q == 4'd0) begin
        t_d = t_q - 4'd1;
        u_d = 4'd9;
      end else begin
        u_d = u_q - 4'd1;
      end
    end else if (!adj_any && en_in) begin
      if (is_23) begin
        t_d = 4'd0;
        u_d = 4'd0;
      end else if (u_q == 4'd9) begin
        t_d = t_q + 4'd1;
        u_d = 4'd0;
      end else begin
        u_d = u_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t_q   <= RstTen;
      u_q   <= RstUnit;
      err_q <= 1'b0;
    end else begin
      t_q   <= t_d;
      u_q   <= u_d;
      err_q <= err_d;
    end
  end

  // Gated by reset_n so a RESET_HOUR of 23 cannot leak a carry while held in reset.
  assign co       = reset_n & en_in & is_23 & !load_en & !adj_any;
  assign load_err = err_q;

  assign hour24_ten  = t_q;
  assign hour24_unit = u_q;

  assign hour_bin = 5'(t_q) * 5'd10 + 5'(u_q);
  assign hour_pm  = hour_bin - 5'd12;
  assign pm       = (hour_bin >= 5'd12);

  always_comb begin
    hour_ten  = t_q;
    hour_unit = u_q;
    if (mode_12h) begin
      if (hour_bin == 5'd0) begin
        hour_ten  = 4'd1;
        hour_unit = 4'd2;
      end else if (hour_bin > 5'd12) begin
        if (hour_pm >= 5'd10) begin
          hour_ten  = 4'd1;
          hour_unit = 4'(hour_pm - 5'd10);
        end else begin
          hour_ten  = 4'd0;
          hour_unit = 4'(hour_pm);
        end
      end
    end
  end

  // Active-low segments, bit order {g,f,e,d,c,b,a}; non-BCD codes blank the digit.
  function automatic logic [6:0] led7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign seg_ten  = led7(hour_ten);
  assign seg_unit = led7(hour_unit);

endmodule

// File: doc/hours_counter_cfg.md
# hours_counter_cfg

Parametrised hours stage for the century clock: a BCD hour counter that always counts internally in 24-hour format (00–23) and presents either a 24-hour or a 12-hour AM/PM display. It adds synchronous load with range checking, non-carrying up/down adjust for time setting, and a chained carry-out that feeds the day stage. It sits between the minutes stage, which drives `en_in`, and the day stage, which consumes `co`. It drives two Led7thanh decoders for the display digits.

## Interface
- `RESET_HOUR`, default 0: hour loaded on reset, in the range 0–23. Values above 23 are illegal and are clamped to 0.

- `clk` in 1: clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `en_in` in 1: one-hour advance request, one cycle per hour, from the minutes stage.
- `mode_12h` in 1: 1 selects 12-hour display, 0 selects 24-hour display. Affects display only.
- `load_en` in 1: synchronous load of `load_ten`/`load_unit`.
- `load_ten` in 4: BCD tens of the load value, 24-hour format.
- `load_unit` in 4: BCD units of the load value, 24-hour format.
- `adj_up` in 1: setting pulse, +1 hour, no carry.
- `adj_dn` in 1: setting pulse, −1 hour, no carry.
- `co` out 1: combinational carry to the day stage.
- `load_err` out 1: registered one-cycle pulse flagging a rejected load.
- `hour24_ten` out 4: raw internal tens digit (0–2).
- `hour24_unit` out 4: raw internal units digit (0–9).
- `hour_ten` out 4: display tens digit, BCD.
- `hour_unit` out 4: display units digit, BCD.
- `pm` out 1: PM flag, valid in both modes.
- `seg_ten` out 7: Led7thanh decode of `hour_ten`.
- `seg_unit` out 7: Led7thanh decode of `hour_unit`.

## Operation
- State: two 4-bit BCD registers `t` and `u`. Legal values are 00–23 only.
- Reset state: `t`,`u` = `RESET_HOUR` in BCD, `load_err`=0.
- Per-cycle priority is `load_en` > adjust (`adj_up`|`adj_dn`) > `en_in`.
  - A cycle that takes a higher-priority action drops that cycle's `en_in` tick.
  - `co` is forced to 0 in that cycle.
- Tick (`en_in`, no load or adjust active):
  - u==9 with t<2: u←0, t←t+1.
  - Count 23: u←0, t←0.
  - Otherwise: u←u+1.
- Carry: `co` = `en_in` & count==23 & !`load_en` & !`adj_up` & !`adj_dn`.
- Adjust: `adj_up` alone increments with 23→00 wrap; `adj_dn` alone decrements with 00→23 wrap. `co` stays 0.
  - Both asserted together: count holds and the tick is still dropped.
- Load, valid case: `load_ten`≤2, `load_unit`≤9, and value ≤23 → count←load value, `load_err`←0.
- Load, invalid case: count holds, `load_err`←1 for exactly one cycle.
- `load_err` is 0 in every cycle not caused by an invalid load.
- `pm` = (count ≥ 12), in both modes.
- Display, 24-hour mode: `hour_ten`/`hour_unit` = `t`/`u`.
- Display, 12-hour mode (tens digit is 0 or 1, never blanked):
  - Hour 0 shows 12.
  - Hours 1–12 show as-is.
  - Hours 13–23 show hour−12 (01–11).
- Toggling `mode_12h` never changes the count. The display follows combinationally in the same cycle.

## Timing
- Load, adjust and tick take effect at the next `clk` rising edge. `hour*`, `pm` and `seg*` follow from the registers, so the new value is visible 1 cycle after the request.
- `co` is combinational: high in the same cycle as the qualifying `en_in`, low again once the count is 00.
- `load_err` is registered: high in the cycle after the invalid `load_en` edge.
- `reset_n` low forces the reset state immediately, with no clock edge needed, including mid-load or mid-adjust. `co` is 0 while in reset.
- Release of `reset_n` is synchronous to `clk` by the upstream reset synchroniser. The first action is accepted on the first edge after release.
- Back-to-back `en_in` on every cycle is legal: one increment per cycle.

## Test plan
- Reset: `RESET_HOUR`=0, `mode_12h`=0 → display 00, `pm`=0, `co`=0, `load_err`=0. With `mode_12h`=1 → display 12, `pm`=0.
- Full day: 24 consecutive `en_in` pulses in 24-hour mode → display 00,01,…,23,00. `co`=1 only in the cycle with count 23 and `en_in`=1.
- 12-hour mapping: load 00, 11, 12, 13, 23 → display/`pm` = 12/0, 11/0, 12/1, 01/1, 11/1.
- Load checks:
  - Load 1,7 → 17, `load_err`=0.
  - Load 2,4 → count unchanged, `load_err`=1 for one cycle.
  - Load 0,0xA → rejected, `load_err`=1.
  - Load 3,0 → rejected, `load_err`=1.
- Adjust and collisions:
  - At 00, `adj_dn` → 23, `co`=0.
  - At 23, `adj_up`+`en_in` in the same cycle → 00, `co`=0.
  - At 05, `adj_up`+`adj_dn` → stays 05.
  - At 23, `load_en`(0,8)+`en_in` → 08, `co`=0.
- Async reset mid-run: at 15 with `en_in` active, drop `reset_n` between clock edges → display 00 before the next edge. After release, the next `en_in` → 01.
